cmd_dispatcher: RTL and testbench
=================================

CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

Interface
REQ-001 SHALL have parameter RF_ADDR_W, default 10, register-file address width.
REQ-002 SHALL have parameter LINE_NUM_W, default 8, line-count width, 1..8.
REQ-003 SHALL have parameter CMD_DEPTH, default 8, command FIFO depth, power of two, at least 2.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, engine watchdog limit in cycles.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  clock, all logic on posedge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 h2f_io  in  32  host command word.
REQ-008 h2f_write  in  1  host write strobe, one word per cycle.
REQ-009 h2f_ready  out  1  FIFO not full.
REQ-010 ld_start/st_start  out  1 each  load/store launch pulse.
REQ-011 ldst_rf_addr  out  RF_ADDR_W; ldst_sdram_addr  out  32; ldst_line_num  out  LINE_NUM_W; ldst_done  in  1.
REQ-012 mv_start  out  1; mv_src_addr/mv_dst_addr  out  RF_ADDR_W; mv_line_num  out  LINE_NUM_W; mv_done  in  1.
REQ-013 eu_fetch/eu_exec  out  32  one-hot per EU id pulse; eu_fetch_addr  out  24; eu_done  in  1.
REQ-014 busy  out  1 (FSM not IDLE or FIFO non-empty); cmd_done  out  1 pulse; overflow  out  1 sticky; timeout  out  1 sticky.

Function
REQ-015 Decode SHALL use h2f_io[31:30]: 00 load, 01 store, 10 move, 11 EU.
REQ-016 For load/store: rf_addr = [29:21] zero-extended/truncated to RF_ADDR_W; sdram_addr = [20:8] zero-extended; line_num = [7:0] truncated to LINE_NUM_W.
REQ-017 For move: src=[29:20], dst=[19:10], [9:8] ignored, line=[7:0], each resized to port width.
REQ-018 For EU: [29]=1 exec, else fetch; id=[28:24] selects the one-hot bit; fetch sets eu_fetch_addr=[23:0]; exec leaves eu_fetch_addr unchanged.
REQ-019 Write with h2f_write=1 and FIFO not full SHALL enqueue; write when full SHALL be dropped and set overflow, fullness judged before any same-cycle pop.
REQ-020 FSM states IDLE, ISSUE, WAIT: IDLE pops head when non-empty -> ISSUE; ISSUE drives the selected start/eu pulse for exactly one cycle -> WAIT; WAIT -> IDLE on the matching done, with cmd_done pulsed that cycle.
REQ-021 Latency from write into empty idle FIFO to start pulse SHALL be 2 cycles.
REQ-022 Done inputs SHALL be ignored outside WAIT and non-matching done ignored in WAIT; ld/st both use ldst_done.
REQ-023 Address/line outputs SHALL hold their values until the next command of that class.
REQ-024 Commands SHALL execute strictly in arrival order, one outstanding at a time.

Reset
REQ-025 Reset SHALL flush FIFO, force IDLE, clear all pulses, addresses, busy, overflow, timeout to 0 and set h2f_ready=1, including mid-WAIT.

Configuration
REQ-026 With CMD_DISPATCHER_TIMEOUT_EN defined, a counter SHALL count WAIT cycles; reaching TIMEOUT_CYC SHALL set timeout, pulse cmd_done and return to IDLE.
REQ-027 Without CMD_DISPATCHER_TIMEOUT_EN, WAIT SHALL persist until done and timeout SHALL be tied to 0.

Structure
REQ-028 Package cmd_dispatcher_pkg SHALL hold the opcode enum, FSM state enum and field bit-position constants.
REQ-029 The FIFO SHALL be sub-module cmd_fifo (parameterised depth/width, full/empty, registered outputs).

Verification
REQ-030 Write {00,9'd0,13'h1234,8'd166} -> ld_start 2 cycles later, rf_addr=0, sdram=0x1234, line=166; ldst_done -> cmd_done.
REQ-031 Write {10,10'd167,10'h200,2'b01,8'd166} -> mv_start, src=167, dst=0x200, line=166.
REQ-032 Fetch {11,0,5'd17,24'h345678} then exec id 17 -> eu_fetch=1<<17 with addr 0x345678, then eu_exec=1<<17 after eu_done.
REQ-033 Hold all done low, write CMD_DEPTH+2 words -> h2f_ready=0 after fill, overflow=1, exactly CMD_DEPTH+1 executed in order.
REQ-034 Assert rst during WAIT -> next cycle IDLE, busy=0, FIFO empty; later done ignored.
REQ-035 With macro, withhold mv_done -> timeout=1 and cmd_done after TIMEOUT_CYC WAIT cycles.

Source files
------------

// File: rtl/cmd_dispatcher_pkg.sv
// Shared opcode/state types and command-word field positions for cmd_dispatcher.
package cmd_dispatcher_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_MOVE  = 2'b10,
    OP_EU    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

  localparam int OP_MSB      = 31;
  localparam int OP_LSB      = 30;
  localparam int LS_RF_MSB   = 29;
  localparam int LS_RF_LSB   = 21;
  localparam int LS_SD_MSB   = 20;
  localparam int LS_SD_LSB   = 8;
  localparam int MV_SRC_MSB  = 29;
  localparam int MV_SRC_LSB  = 20;
  localparam int MV_DST_MSB  = 19;
  localparam int MV_DST_LSB  = 10;
  localparam int LINE_MSB    = 7;
  localparam int LINE_LSB    = 0;
  localparam int EU_EXEC_BIT = 29;
  localparam int EU_ID_MSB   = 28;
  localparam int EU_ID_LSB   = 24;
  localparam int EU_ADDR_MSB = 23;
  localparam int EU_ADDR_LSB = 0;

  // Right-justified, zero-extended copy of word[msb:lsb].
  function automatic logic [31:0] get_field(input logic [31:0] word, input int msb, input int lsb);
    logic [31:0] mask;
    mask = (32'd1 << (msb - lsb + 1)) - 32'd1;
    return (word >> lsb) & mask;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered full/empty flags and a show-ahead head word.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~r_full;
  assign w_do_pop  = i_pop & ~r_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    w_count_next = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + (AW+1)'(1);
      2'b01:   w_count_next = r_count - (AW+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, count and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == (AW+1)'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Queues host command words and launches load/store, move or EU work one command at a time, in order.
// Optional WAIT-state watchdog is built in when CMD_DISPATCHER_TIMEOUT_EN is defined.
module cmd_dispatcher
  import cmd_dispatcher_pkg::*;
#(
  parameter int RF_ADDR_W   = 10,
  parameter int LINE_NUM_W  = 8,
  parameter int CMD_DEPTH   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           h2f_io,
  input  logic                  h2f_write,
  output logic                  h2f_ready,
  output logic                  ld_start,
  output logic                  st_start,
  output logic [RF_ADDR_W-1:0]  ldst_rf_addr,
  output logic [31:0]           ldst_sdram_addr,
  output logic [LINE_NUM_W-1:0] ldst_line_num,
  input  logic                  ldst_done,
  output logic                  mv_start,
  output logic [RF_ADDR_W-1:0]  mv_src_addr,
  output logic [RF_ADDR_W-1:0]  mv_dst_addr,
  output logic [LINE_NUM_W-1:0] mv_line_num,
  input  logic                  mv_done,
  output logic [31:0]           eu_fetch,
  output logic [31:0]           eu_exec,
  output logic [23:0]           eu_fetch_addr,
  input  logic                  eu_done,
  output logic                  busy,
  output logic                  cmd_done,
  output logic                  overflow,
  output logic                  timeout
);

  state_e r_state;
  state_e w_next_state;
  op_e    r_op;
  op_e    w_head_op;

  logic [31:0] w_head;
  logic [31:0] w_eu_onehot;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_match;
  logic        w_to_hit;
  logic        w_cmd_done;

  logic                  r_ld_start;
  logic                  r_st_start;
  logic                  r_mv_start;
  logic [31:0]           r_eu_fetch;
  logic [31:0]           r_eu_exec;
  logic [RF_ADDR_W-1:0]  r_ldst_rf_addr;
  logic [31:0]           r_ldst_sdram_addr;
  logic [LINE_NUM_W-1:0] r_ldst_line_num;
  logic [RF_ADDR_W-1:0]  r_mv_src_addr;
  logic [RF_ADDR_W-1:0]  r_mv_dst_addr;
  logic [LINE_NUM_W-1:0] r_mv_line_num;
  logic [23:0]           r_eu_fetch_addr;
  logic                  r_overflow;

  // Fullness is the registered flag, so a write into a full FIFO is dropped even if a pop happens the same cycle.
  assign w_push      = h2f_write & ~w_full;
  assign w_head_op   = op_e'(w_head[OP_MSB:OP_LSB]);
  assign w_eu_onehot = 32'd1 << w_head[EU_ID_MSB:EU_ID_LSB];

  cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (32)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (h2f_io),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Completion strobe belonging to the outstanding command's class.
  always_comb begin
    w_match = 1'b0;
    case (r_op)
      OP_LOAD, OP_STORE: w_match = ldst_done;
      OP_MOVE:           w_match = mv_done;
      OP_EU:             w_match = eu_done;
      default:           w_match = 1'b0;
    endcase
  end

`ifdef CMD_DISPATCHER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;

  assign w_to_hit = (r_state == ST_WAIT) && !w_match && (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign timeout  = r_timeout;

  // WAIT-cycle watchdog; the hit cycle itself is the TIMEOUT_CYC-th WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if ((r_state == ST_WAIT) && !w_match && !w_to_hit) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_to_hit         = 1'b0;
  assign timeout          = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYC > 0);
`endif

  // Next-state logic, head pop and completion strobe.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_cmd_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (w_match || w_to_hit) begin
          w_cmd_done   = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (h2f_write && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Launch registers: pulses are loaded on the pop so they are visible exactly during ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op              <= OP_LOAD;
      r_ld_start        <= 1'b0;
      r_st_start        <= 1'b0;
      r_mv_start        <= 1'b0;
      r_eu_fetch        <= '0;
      r_eu_exec         <= '0;
      r_ldst_rf_addr    <= '0;
      r_ldst_sdram_addr <= '0;
      r_ldst_line_num   <= '0;
      r_mv_src_addr     <= '0;
      r_mv_dst_addr     <= '0;
      r_mv_line_num     <= '0;
      r_eu_fetch_addr   <= '0;
    end else begin
      r_ld_start <= 1'b0;
      r_st_start <= 1'b0;
      r_mv_start <= 1'b0;
      r_eu_fetch <= '0;
      r_eu_exec  <= '0;
      if (w_pop) begin
        r_op <= w_head_op;
        case (w_head_op)
          OP_LOAD, OP_STORE: begin
            r_ld_start        <= (w_head_op == OP_LOAD);
            r_st_start        <= (w_head_op == OP_STORE);
            r_ldst_rf_addr    <= RF_ADDR_W'(get_field(w_head, LS_RF_MSB, LS_RF_LSB));
            r_ldst_sdram_addr <= get_field(w_head, LS_SD_MSB, LS_SD_LSB);
            r_ldst_line_num   <= LINE_NUM_W'(get_field(w_head, LINE_MSB, LINE_LSB));
          end
          OP_MOVE: begin
            r_mv_start    <= 1'b1;
            r_mv_src_addr <= RF_ADDR_W'(get_field(w_head, MV_SRC_MSB, MV_SRC_LSB));
            r_mv_dst_addr <= RF_ADDR_W'(get_field(w_head, MV_DST_MSB, MV_DST_LSB));
            r_mv_line_num <= LINE_NUM_W'(get_field(w_head, LINE_MSB, LINE_LSB));
          end
          OP_EU: begin
            if (w_head[EU_EXEC_BIT]) begin
              r_eu_exec <= w_eu_onehot;
            end else begin
              r_eu_fetch      <= w_eu_onehot;
              r_eu_fetch_addr <= 24'(get_field(w_head, EU_ADDR_MSB, EU_ADDR_LSB));
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign h2f_ready       = ~w_full;
  assign busy            = (r_state != ST_IDLE) || !w_empty;
  assign cmd_done        = w_cmd_done;
  assign overflow        = r_overflow;
  assign ld_start        = r_ld_start;
  assign st_start        = r_st_start;
  assign mv_start        = r_mv_start;
  assign eu_fetch        = r_eu_fetch;
  assign eu_exec         = r_eu_exec;
  assign ldst_rf_addr    = r_ldst_rf_addr;
  assign ldst_sdram_addr = r_ldst_sdram_addr;
  assign ldst_line_num   = r_ldst_line_num;
  assign mv_src_addr     = r_mv_src_addr;
  assign mv_dst_addr     = r_mv_dst_addr;
  assign mv_line_num     = r_mv_line_num;
  assign eu_fetch_addr   = r_eu_fetch_addr;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Self-checking bench for cmd_dispatcher: vector table, in-order launch scoreboard, overflow, reset and watchdog cases.
`timescale 1ns/1ps
module tb_cmd_dispatcher;

  localparam int RF_W   = 10;
  localparam int LN_W   = 8;
  localparam int DEPTH  = 8;
  localparam int TO_CYC = 24;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     h2f_io;
  logic            h2f_write;
  logic            h2f_ready;
  logic            ld_start, st_start, mv_start;
  logic [RF_W-1:0] ldst_rf_addr, mv_src_addr, mv_dst_addr;
  logic [31:0]     ldst_sdram_addr;
  logic [LN_W-1:0] ldst_line_num, mv_line_num;
  logic            ldst_done, mv_done, eu_done;
  logic [31:0]     eu_fetch, eu_exec;
  logic [23:0]     eu_fetch_addr;
  logic            busy, cmd_done, overflow, timeout;

  cmd_dispatcher #(
    .RF_ADDR_W (RF_W), .LINE_NUM_W (LN_W), .CMD_DEPTH (DEPTH), .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk (clk), .rst (rst), .h2f_io (h2f_io), .h2f_write (h2f_write), .h2f_ready (h2f_ready),
    .ld_start (ld_start), .st_start (st_start), .ldst_rf_addr (ldst_rf_addr),
    .ldst_sdram_addr (ldst_sdram_addr), .ldst_line_num (ldst_line_num), .ldst_done (ldst_done),
    .mv_start (mv_start), .mv_src_addr (mv_src_addr), .mv_dst_addr (mv_dst_addr),
    .mv_line_num (mv_line_num), .mv_done (mv_done),
    .eu_fetch (eu_fetch), .eu_exec (eu_exec), .eu_fetch_addr (eu_fetch_addr), .eu_done (eu_done),
    .busy (busy), .cmd_done (cmd_done), .overflow (overflow), .timeout (timeout)
  );

  always #5 clk = ~clk;

  // kind: 0 load, 1 store, 2 move, 3 EU fetch, 4 EU exec
  typedef struct {
    logic [31:0] cmd;
    int          kind;
    logic [9:0]  a;
    logic [31:0] b;
    logic [7:0]  line;
    logic [4:0]  id;
    logic [23:0] fa;
  } vec_t;

  typedef struct {
    logic        ld, st, mv;
    logic [31:0] fe, ex;
    logic [9:0]  rf;
    logic [31:0] sd;
    logic [7:0]  ll;
    logic [9:0]  src, dst;
    logic [7:0]  ml;
    logic [23:0] fa;
  } snap_t;

  vec_t  vecs[9];
  snap_t sh;
  snap_t sbq[$];
  snap_t s;
  int    total = 0, bad = 0, cyc = 0, launches = 0, launch_cyc = 0, wcyc = 0, tgt = 0, n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_shadow();
    sh.ld = 1'b0; sh.st = 1'b0; sh.mv = 1'b0; sh.fe = '0; sh.ex = '0;
    sh.rf = '0; sh.sd = '0; sh.ll = '0; sh.src = '0; sh.dst = '0; sh.ml = '0; sh.fa = '0;
  endtask

  // Expected full output picture at the launch of v; held fields carry over from earlier commands.
  task automatic next_snap(input vec_t v, output snap_t o);
    o = sh;
    o.ld = 1'b0; o.st = 1'b0; o.mv = 1'b0; o.fe = '0; o.ex = '0;
    case (v.kind)
      0, 1: begin
        o.ld = (v.kind == 0); o.st = (v.kind == 1);
        o.rf = v.a; o.sd = v.b; o.ll = v.line;
      end
      2: begin o.mv = 1'b1; o.src = v.a; o.dst = v.b[9:0]; o.ml = v.line; end
      3: begin o.fe = 32'd1 << v.id; o.fa = v.fa; end
      default: o.ex = 32'd1 << v.id;
    endcase
    sh = o;
  endtask

  task automatic check_launch();
    snap_t e;
    if (ld_start || st_start || mv_start || (eu_fetch != 32'd0) || (eu_exec != 32'd0)) begin
      launches++;
      launch_cyc = cyc;
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_launch: got a launch at cycle %0d want none", cyc);
      end else begin
        e = sbq.pop_front();
        chk("ld_start", ld_start, e.ld);
        chk("st_start", st_start, e.st);
        chk("mv_start", mv_start, e.mv);
        chk("eu_fetch", eu_fetch, e.fe);
        chk("eu_exec", eu_exec, e.ex);
        chk("ldst_rf_addr", ldst_rf_addr, e.rf);
        chk("ldst_sdram_addr", ldst_sdram_addr, e.sd);
        chk("ldst_line_num", ldst_line_num, e.ll);
        chk("mv_src_addr", mv_src_addr, e.src);
        chk("mv_dst_addr", mv_dst_addr, e.dst);
        chk("mv_line_num", mv_line_num, e.ml);
        chk("eu_fetch_addr", eu_fetch_addr, e.fa);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_launch();
  endtask

  task automatic drive_word(input logic [31:0] w);
    h2f_io = w; h2f_write = 1'b1; wcyc = cyc;
    tick();
    h2f_write = 1'b0;
  endtask

  task automatic set_done(input int kind, input logic match_v, input logic wrong_v);
    ldst_done = (kind <= 1) ? match_v : wrong_v;
    mv_done   = (kind == 2) ? match_v : wrong_v;
    eu_done   = (kind >= 3) ? match_v : wrong_v;
  endtask

  task automatic wait_launch(input int target, input string nm);
    int k;
    k = 0;
    while (launches < target && k < 40) begin
      tick();
      k++;
    end
    if (launches < target) chk(nm, launches, target);
  endtask

  initial begin
    vecs[0] = '{cmd: {2'b00, 9'd0, 13'h1234, 8'd166}, kind: 0, a: 10'd0, b: 32'h1234, line: 8'd166, id: 5'd0, fa: 24'd0};
    vecs[1] = '{cmd: {2'b01, 9'd511, 13'h1FFF, 8'd255}, kind: 1, a: 10'd511, b: 32'h1FFF, line: 8'd255, id: 5'd0, fa: 24'd0};
    vecs[2] = '{cmd: {2'b10, 10'd167, 10'h200, 2'b01, 8'd166}, kind: 2, a: 10'd167, b: 32'h200, line: 8'd166, id: 5'd0, fa: 24'd0};
    vecs[3] = '{cmd: {2'b11, 1'b0, 5'd17, 24'h345678}, kind: 3, a: 10'd0, b: 32'd0, line: 8'd0, id: 5'd17, fa: 24'h345678};
    vecs[4] = '{cmd: {2'b11, 1'b1, 5'd17, 24'h000000}, kind: 4, a: 10'd0, b: 32'd0, line: 8'd0, id: 5'd17, fa: 24'd0};
    vecs[5] = '{cmd: {2'b10, 10'h3FF, 10'd0, 2'b11, 8'd0}, kind: 2, a: 10'h3FF, b: 32'd0, line: 8'd0, id: 5'd0, fa: 24'd0};
    vecs[6] = '{cmd: {2'b11, 1'b0, 5'd31, 24'hABCDEF}, kind: 3, a: 10'd0, b: 32'd0, line: 8'd0, id: 5'd31, fa: 24'hABCDEF};
    vecs[7] = '{cmd: {2'b11, 1'b1, 5'd0, 24'hFFFFFF}, kind: 4, a: 10'd0, b: 32'd0, line: 8'd0, id: 5'd0, fa: 24'd0};
    vecs[8] = '{cmd: {2'b00, 9'h155, 13'h0AAA, 8'd1}, kind: 0, a: 10'h155, b: 32'h0AAA, line: 8'd1, id: 5'd0, fa: 24'd0};
    clear_shadow();
    h2f_io = 32'd0; h2f_write = 1'b0;
    set_done(0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("rst_ready", h2f_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulses", {ld_start, st_start, mv_start, cmd_done}, 4'd0);
    chk("rst_eu", eu_fetch | eu_exec, 32'd0);
    chk("rst_flags", {overflow, timeout}, 2'd0);
    chk("rst_addr", eu_fetch_addr, 24'd0);
    rst = 1'b0;
    tick();

    set_done(0, 1'b1, 1'b1);
    tick();
    chk("idle_done_ignored", cmd_done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    set_done(0, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      next_snap(vecs[i], s);
      sbq.push_back(s);
      tgt = launches + 1;
      drive_word(vecs[i].cmd);
      wait_launch(tgt, "launch_wait");
      chk("latency", launch_cyc - wcyc, 2);
      set_done(vecs[i].kind, 1'b1, 1'b0);
      tick();
      set_done(vecs[i].kind, 1'b0, 1'b0);
      #1 chk("busy_wait", busy, 1'b1);
      set_done(vecs[i].kind, 1'b0, 1'b1);
      #1 chk("wrong_done", cmd_done, 1'b0);
      set_done(vecs[i].kind, 1'b1, 1'b0);
      #1 chk("cmd_done", cmd_done, 1'b1);
      tick();
      set_done(vecs[i].kind, 1'b0, 1'b0);
      #1 chk("busy_idle", busy, 1'b0);
    end

    for (int i = 0; i < 9; i++) begin
      next_snap(vecs[i], s);
      sbq.push_back(s);
    end
    tgt = launches;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i == DEPTH + 1) begin
        chk("ready_full", h2f_ready, 1'b0);
        chk("ovf_before", overflow, 1'b0);
      end
      h2f_io = (i < DEPTH + 1) ? vecs[i].cmd : 32'hC0FF_EE00;
      h2f_write = 1'b1;
      tick();
    end
    h2f_write = 1'b0;
    chk("overflow", overflow, 1'b1);
    chk("ready_after", h2f_ready, 1'b0);
    for (int k = 0; k < DEPTH + 1; k++) begin
      wait_launch(tgt + k + 1, "ovf_launch_wait");
      tick();
      set_done(vecs[k].kind, 1'b1, 1'b0);
      #1 chk("ovf_cmd_done", cmd_done, 1'b1);
      tick();
      set_done(vecs[k].kind, 1'b0, 1'b0);
    end
    repeat (6) tick();
    chk("ovf_launch_count", launches, tgt + DEPTH + 1);
    chk("sb_empty", sbq.size(), 0);
    chk("busy_end", busy, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);

`ifdef CMD_DISPATCHER_TIMEOUT_EN
    next_snap(vecs[2], s);
    sbq.push_back(s);
    tgt = launches + 1;
    drive_word(vecs[2].cmd);
    wait_launch(tgt, "to_launch_wait");
    tick();
    n = 1;
    while (!cmd_done && n < TO_CYC + 10) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TO_CYC);
    chk("timeout_pre", timeout, 1'b0);
    tick();
    chk("timeout_set", timeout, 1'b1);
    chk("timeout_idle", busy, 1'b0);
`else
    chk("timeout_tied", timeout, 1'b0);
`endif

    next_snap(vecs[5], s);
    sbq.push_back(s);
    tgt = launches + 1;
    drive_word(vecs[5].cmd);
    wait_launch(tgt, "rst_launch_wait");
    tick();
    drive_word(vecs[0].cmd);
    chk("rst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", h2f_ready, 1'b1);
    chk("midrst_mv_src", mv_src_addr, 10'd0);
    chk("midrst_ld_rf", ldst_rf_addr, 10'd0);
    chk("midrst_flags", {overflow, timeout}, 2'd0);
    chk("midrst_fa", eu_fetch_addr, 24'd0);
    sbq.delete();
    clear_shadow();
    tick();
    rst = 1'b0;
    tgt = launches;
    set_done(2, 1'b1, 1'b1);
    tick();
    chk("rst_done_ignored", cmd_done, 1'b0);
    set_done(2, 1'b0, 1'b0);
    repeat (3) tick();
    chk("rst_no_launch", launches, tgt);
    chk("rst_idle_busy", busy, 1'b0);

    next_snap(vecs[1], s);
    sbq.push_back(s);
    tgt = launches + 1;
    drive_word(vecs[1].cmd);
    wait_launch(tgt, "post_rst_launch");
    chk("post_rst_latency", launch_cyc - wcyc, 2);
    tick();
    set_done(1, 1'b1, 1'b0);
    #1 chk("post_rst_done", cmd_done, 1'b1);
    tick();
    set_done(1, 1'b0, 1'b0);
    #1 chk("post_rst_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us want finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
